// File: rtl/pulse_compression_controller.sv
// Burst sequencer for the pulse compression filter: per pulse it waits for the PRF
// trigger, clears and primes the filter, then forwards OUTPUT_LENGTH tagged samples.
module pulse_compression_controller #(
    parameter int OUTPUT_LENGTH = 14400,
    parameter int PIPE_LATENCY  = 13,
    parameter int NUM_PULSES    = 16,
    parameter int COUNT_WIDTH   = 14,
    parameter int PULSE_WIDTH   = 5
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   trigger,
    input  logic                   clearError,
    input  logic [31:0]            MFOutput,
    output logic                   filterEnable,
    output logic                   filterClear,
    output logic [31:0]            outData,
    output logic                   outValid,
    output logic                   outLast,
    output logic [PULSE_WIDTH-1:0] pulseIndex,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    localparam int LAT_W = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;
    localparam logic [COUNT_WIDTH-1:0] LAST_SAMPLE = COUNT_WIDTH'(OUTPUT_LENGTH - 1);
    localparam logic [LAT_W-1:0]       LAST_LAT    = LAT_W'(PIPE_LATENCY - 1);
    localparam logic [PULSE_WIDTH-1:0] LAST_PULSE  = PULSE_WIDTH'(NUM_PULSES - 1);

    typedef enum logic [2:0] {IDLE, WAIT_TRIG, CLEAR, PRIME, STREAM, DONE} state_t;

    state_t                 state;
    logic [COUNT_WIDTH-1:0] sample_cnt;
    logic [LAT_W-1:0]       lat_cnt;
    logic [PULSE_WIDTH-1:0] pulse_cnt;

    assign busy = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            sample_cnt   <= '0;
            lat_cnt      <= '0;
            pulse_cnt    <= '0;
            filterEnable <= 1'b0;
            filterClear  <= 1'b0;
            outData      <= '0;
            outValid     <= 1'b0;
            outLast      <= 1'b0;
            pulseIndex   <= '0;
            done         <= 1'b0;
            overrun      <= 1'b0;
        end else if (abort) begin
            // Overrun is deliberately left alone so a cancelled burst keeps its error history.
            state        <= IDLE;
            sample_cnt   <= '0;
            lat_cnt      <= '0;
            pulse_cnt    <= '0;
            filterEnable <= 1'b0;
            filterClear  <= 1'b0;
            outValid     <= 1'b0;
            outLast      <= 1'b0;
            done         <= 1'b0;
        end else begin
            filterClear <= 1'b0;
            outValid    <= 1'b0;
            outLast     <= 1'b0;
            done        <= 1'b0;

            // A fresh overrun wins over a same-cycle clear.
            if (clearError)
                overrun <= 1'b0;
            if (trigger && (state inside {CLEAR, PRIME, STREAM, DONE}))
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= WAIT_TRIG;
                        pulse_cnt <= '0;
                    end
                end
                WAIT_TRIG: begin
                    if (trigger) begin
                        state       <= CLEAR;
                        filterClear <= 1'b1;
                    end
                end
                CLEAR: begin
                    state        <= PRIME;
                    filterEnable <= 1'b1;
                    lat_cnt      <= '0;
                end
                PRIME: begin
                    if (lat_cnt == LAST_LAT) begin
                        state      <= STREAM;
                        lat_cnt    <= '0;
                        sample_cnt <= '0;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                STREAM: begin
                    outData    <= MFOutput;
                    outValid   <= 1'b1;
                    pulseIndex <= pulse_cnt;
                    outLast    <= (sample_cnt == LAST_SAMPLE);
                    if (sample_cnt == LAST_SAMPLE) begin
                        filterEnable <= 1'b0;
                        sample_cnt   <= '0;
                        if (pulse_cnt == LAST_PULSE) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= WAIT_TRIG;
                            pulse_cnt <= pulse_cnt + 1'b1;
                        end
                    end else begin
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    pulse_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_compression_controller.sv
// Directed bench for pulse_compression_controller with OUTPUT_LENGTH=8, PIPE_LATENCY=3,
// NUM_PULSES=2; cycle k below counts cycles after the one in which the trigger is high.
module tb_pulse_compression_controller;

    localparam int OL = 8;
    localparam int PL = 3;
    localparam int NP = 2;
    localparam int PW = 2;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start, abort, trigger, clearError;
    logic [31:0]   MFOutput;
    logic          filterEnable, filterClear, outValid, outLast, busy, done, overrun;
    logic [31:0]   outData;
    logic [PW-1:0] pulseIndex;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    pulse_compression_controller #(
        .OUTPUT_LENGTH(OL), .PIPE_LATENCY(PL), .NUM_PULSES(NP),
        .COUNT_WIDTH(4), .PULSE_WIDTH(PW)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .trigger(trigger), .clearError(clearError), .MFOutput(MFOutput),
        .filterEnable(filterEnable), .filterClear(filterClear), .outData(outData),
        .outValid(outValid), .outLast(outLast), .pulseIndex(pulseIndex),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clock = ~clock;

    // Incrementing sample source; outData must lag it by exactly one clock.
    always @(posedge clock) MFOutput <= MFOutput + 32'd1;
    always @(negedge clock) if (done) done_cnt++;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One pulse starting from WAIT_TRIG. ovk!=0 injects a trigger during cycle ovk
    // (optionally with clearError) and expects overrun=1 afterwards.
    task automatic run_pulse(input int idx, input bit last, input int ovk, input bit clr);
        int nvalid;
        nvalid = 0;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        chk("clear_k1", filterClear, 1);
        chk("enable_k1", filterEnable, 0);
        for (int k = 2; k <= 14; k++) begin
            trigger    = (ovk != 0) && (k - 1 == ovk);
            clearError = trigger && clr;
            tick();
            trigger    = 1'b0;
            clearError = 1'b0;
            chk("clear", filterClear, 0);
            chk("enable", filterEnable, (k <= 12) ? 1 : 0);
            chk("valid", outValid, (k >= 6 && k <= 13) ? 1 : 0);
            chk("last", outLast, (k == 13) ? 1 : 0);
            chk("done", done, (last && k == 13) ? 1 : 0);
            if (outValid) begin
                nvalid++;
                chk("data", outData, MFOutput - 32'd1);
                chk("pidx", pulseIndex, idx);
            end
            if (ovk != 0 && k == ovk + 1) chk("ovr_set", overrun, 1);
        end
        chk("nsamples", nvalid, OL);
        chk("busy_after", busy, last ? 0 : 1);
    endtask

    initial begin
        reset_n = 1'b0; start = 0; abort = 0; trigger = 0; clearError = 0;
        MFOutput = 32'h100;

        // Reset with random inputs
        for (int i = 0; i < 5; i++) begin
            start = 1'($urandom); abort = 1'($urandom); trigger = 1'($urandom);
            clearError = 1'($urandom);
            tick();
            chk("rst_outs", {filterEnable, filterClear, outValid, outLast, busy, done, overrun}, 0);
            chk("rst_data", outData, 0);
            chk("rst_pidx", pulseIndex, 0);
        end
        start = 0; abort = 0; trigger = 0; clearError = 0;
        reset_n = 1'b1;
        tick(); tick();
        chk("idle_busy", busy, 0);

        // Trigger in IDLE is ignored
        trigger = 1'b1; tick(); trigger = 1'b0; tick();
        chk("idle_trig_busy", busy, 0);
        chk("idle_trig_ovr", overrun, 0);
        chk("idle_trig_clr", filterClear, 0);

        // Burst 1: start twice (second ignored), overrun trigger in pulse-0 STREAM
        start = 1'b1; tick(); start = 1'b0;
        chk("start_busy", busy, 1);
        start = 1'b1; tick(); start = 1'b0; tick();
        chk("wait_busy", busy, 1);
        run_pulse(0, 1'b0, 8, 1'b0);
        tick(); tick(); tick();
        chk("wait_no_enable", filterEnable, 0);
        chk("wait_no_clear", filterClear, 0);
        chk("ovr_sticky", overrun, 1);
        clearError = 1'b1; tick(); clearError = 1'b0;
        chk("ovr_cleared", overrun, 0);
        run_pulse(1, 1'b1, 0, 1'b0);
        tick();
        chk("idle_after", busy, 0);
        chk("done_once", done_cnt, 1);

        // Burst 2: overrun in pulse 0, then clearError + trigger together in pulse 1 PRIME
        start = 1'b1; tick(); start = 1'b0;
        run_pulse(0, 1'b0, 10, 1'b0);
        run_pulse(1, 1'b1, 3, 1'b1);
        chk("ovr_clr_race", overrun, 1);
        chk("done_twice", done_cnt, 2);
        clearError = 1'b1; tick(); clearError = 1'b0;
        chk("ovr_clr2", overrun, 0);

        // Abort at the 4th outValid cycle
        start = 1'b1; tick(); start = 1'b0;
        trigger = 1'b1; tick(); trigger = 1'b0;
        for (int k = 2; k <= 9; k++) tick();
        chk("abort_pre_valid", outValid, 1);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_valid", outValid, 0);
        chk("abort_enable", filterEnable, 0);
        chk("abort_busy", busy, 0);
        chk("abort_last", outLast, 0);
        for (int i = 0; i < 10; i++) tick();
        chk("abort_no_done", done_cnt, 2);
        chk("abort_ovr", overrun, 0);

        // Fresh burst after abort starts at pulse 0
        start = 1'b1; tick(); start = 1'b0;
        run_pulse(0, 1'b0, 0, 1'b0);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("end_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
